dmx_rx: RTL and testbench

//  DMX512 receiver and the counterpart of DMX_Tx; same 250 kbit/s 8N2 line format.

---
 rtl/dmx_rx.sv | 189 ++++++++++++++++++
 tb/tb_dmx_rx.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmx_rx.sv
// dmx_rx - DMX512 receiver (250 kbit/s, 8N2).
// Decodes BREAK / MAB / start code from the synchronised RS-485 line, captures
// the one slot selected by addr, and reports packet completion, framing errors
// and signal presence.
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   rx           DMX line, idle high, asynchronous to clk
//   addr         wanted slot (latched at each BREAK); 0 selects nothing
//   dmx_data     last captured value of the addressed slot
//   data_valid   1-cycle pulse when dmx_data is updated
//   packet_done  1-cycle pulse when a packet with start code 0x00 is closed
//   last_slots   number of data slots in the closed packet (0..512)
//   frame_err    1-cycle pulse on a low stop bit that does not turn into a BREAK
//   signal_ok    high while packets keep arriving
module dmx_rx #(
   parameter int CLK_FREQ     = 12090000,
   parameter int BAUD_RATE    = 250000,
   parameter int BREAK_MIN_US = 88,
   parameter int TIMEOUT_MS   = 1000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx,
   input  logic [8:0] addr,
   output logic [7:0] dmx_data,
   output logic       data_valid,
   output logic       packet_done,
   output logic [9:0] last_slots,
   output logic       frame_err,
   output logic       signal_ok
);

   localparam int BIT_CYC   = CLK_FREQ / BAUD_RATE;
   localparam int HALF_CYC  = BIT_CYC / 2;
   localparam int BREAK_CYC = (CLK_FREQ / 1000000) * BREAK_MIN_US;
   localparam int TMO_CYC   = TIMEOUT_MS * (CLK_FREQ / 1000);

   localparam logic [15:0] BIT_LAST  = 16'(BIT_CYC - 1);
   localparam logic [15:0] HALF_LAST = 16'(HALF_CYC - 1);
   localparam logic [31:0] BREAK_LIM = 32'(BREAK_CYC);
   localparam logic [31:0] TMO_LAST  = 32'(TMO_CYC - 1);

   typedef enum logic [2:0] {IDLE, MAB, START, DATA, STOP, ERRWAIT} state_t;

   state_t      state;
   logic        rx_m, rxs, rxs_d;
   logic [31:0] low_cnt;
   logic [31:0] tmo_cnt;
   logic [15:0] cyc_cnt;
   logic [2:0]  bit_idx;
   logic [7:0]  shreg;
   logic [9:0]  slot_cnt;   // data slots completed in the open packet
   logic [8:0]  addr_l;
   logic        sc_ok;      // open packet has start code 0x00

   logic        rise, fall, brk;
   logic [9:0]  nxt_slot;

   assign rise     = rxs & ~rxs_d;
   assign fall     = ~rxs & rxs_d;
   assign brk      = rise && (low_cnt >= BREAK_LIM);
   assign nxt_slot = slot_cnt + 10'd1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_m        <= 1'b1;
         rxs         <= 1'b1;
         rxs_d       <= 1'b1;
         state       <= IDLE;
         low_cnt     <= '0;
         tmo_cnt     <= '0;
         cyc_cnt     <= '0;
         bit_idx     <= '0;
         shreg       <= '0;
         slot_cnt    <= '0;
         addr_l      <= '0;
         sc_ok       <= 1'b0;
         dmx_data    <= '0;
         data_valid  <= 1'b0;
         packet_done <= 1'b0;
         last_slots  <= '0;
         frame_err   <= 1'b0;
         signal_ok   <= 1'b0;
      end else begin
         rx_m        <= rx;
         rxs         <= rx_m;
         rxs_d       <= rxs;
         data_valid  <= 1'b0;
         packet_done <= 1'b0;
         frame_err   <= 1'b0;

         // Low-time counter saturates once a BREAK length has been seen.
         if (!rxs) begin
            if (low_cnt < BREAK_LIM) low_cnt <= low_cnt + 32'd1;
         end else begin
            low_cnt <= '0;
         end

         // Timeout saturates; signal_ok stays low until the next packet_done.
         if (tmo_cnt < TMO_LAST) tmo_cnt <= tmo_cnt + 32'd1;
         else                    signal_ok <= 1'b0;

         if (brk) begin
            // BREAK wins over whatever the slot FSM was doing.
            if (sc_ok) begin
               packet_done <= 1'b1;
               last_slots  <= slot_cnt;
               signal_ok   <= 1'b1;
            end
            addr_l   <= addr;
            slot_cnt <= '0;
            sc_ok    <= 1'b0;
            tmo_cnt  <= '0;
            state    <= MAB;
         end else begin
            case (state)
               IDLE: ;
               MAB: begin
                  if (fall) begin
                     cyc_cnt <= '0;
                     state   <= START;
                  end
               end
               START: begin
                  if (cyc_cnt == HALF_LAST) begin
                     cyc_cnt <= '0;
                     bit_idx <= '0;
                     state   <= rxs ? MAB : DATA;   // high at centre = glitch
                  end else begin
                     cyc_cnt <= cyc_cnt + 16'd1;
                  end
               end
               DATA: begin
                  if (cyc_cnt == BIT_LAST) begin
                     cyc_cnt <= '0;
                     shreg   <= {rxs, shreg[7:1]};  // LSB arrives first
                     bit_idx <= bit_idx + 3'd1;
                     if (bit_idx == 3'd7) state <= STOP;
                  end else begin
                     cyc_cnt <= cyc_cnt + 16'd1;
                  end
               end
               STOP: begin
                  if (cyc_cnt == BIT_LAST) begin
                     cyc_cnt <= '0;
                     if (!rxs) begin
                        state <= ERRWAIT;
                     end else if (!sc_ok) begin
                        // First slot after BREAK is the start code.
                        sc_ok    <= (shreg == 8'h00);
                        slot_cnt <= '0;
                        state    <= (shreg == 8'h00) ? MAB : IDLE;
                     end else begin
                        if (nxt_slot == {1'b0, addr_l}) begin
                           dmx_data   <= shreg;
                           data_valid <= 1'b1;
                        end
                        if (nxt_slot == 10'd512) begin
                           packet_done <= 1'b1;
                           last_slots  <= 10'd512;
                           signal_ok   <= 1'b1;
                           sc_ok       <= 1'b0;
                           slot_cnt    <= nxt_slot;
                           state       <= IDLE;
                        end else begin
                           slot_cnt <= nxt_slot;
                           state    <= MAB;
                        end
                     end
                  end else begin
                     cyc_cnt <= cyc_cnt + 16'd1;
                  end
               end
               ERRWAIT: begin
                  // A rise that qualifies as BREAK is handled above.
                  if (rise) begin
                     frame_err <= 1'b1;
                     sc_ok     <= 1'b0;
                     state     <= IDLE;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_dmx_rx.sv
module tb_dmx_rx;

   localparam int CLKF = 2000000;
   localparam int BIT  = CLKF / 250000;   // 8 cycles per bit

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rx = 1'b1;
   logic [8:0] addr = '0;
   logic [7:0] dmx_data;
   logic       data_valid, packet_done, frame_err, signal_ok;
   logic [9:0] last_slots;

   int total = 0;
   int bad   = 0;
   int fe_seen = 0;

   logic [7:0] exp_dv[$];
   logic [9:0] exp_pd[$];

   dmx_rx #(.CLK_FREQ(CLKF), .BAUD_RATE(250000), .BREAK_MIN_US(88), .TIMEOUT_MS(1)) dut (
      .clk(clk), .rst_n(rst_n), .rx(rx), .addr(addr),
      .dmx_data(dmx_data), .data_valid(data_valid), .packet_done(packet_done),
      .last_slots(last_slots), .frame_err(frame_err), .signal_ok(signal_ok)
   );

   always #5 clk = ~clk;

   // One clock; pops the scoreboard whenever the DUT emits a pulse.
   task automatic tick();
      logic [7:0] ed;
      logic [9:0] ep;
      @(posedge clk); #1;
      if (data_valid === 1'b1) begin
         total++;
         if (exp_dv.size() == 0) begin
            bad++; $display("FAIL dv_unexpected data=%h want=no_pulse", dmx_data);
         end else begin
            ed = exp_dv.pop_front();
            if (dmx_data !== ed) begin bad++; $display("FAIL dv_data got=%h want=%h", dmx_data, ed); end
         end
      end
      if (packet_done === 1'b1) begin
         total++;
         if (exp_pd.size() == 0) begin
            bad++; $display("FAIL pd_unexpected slots=%0d want=no_pulse", last_slots);
         end else begin
            ep = exp_pd.pop_front();
            if (last_slots !== ep) begin bad++; $display("FAIL pd_slots got=%0d want=%0d", last_slots, ep); end
         end
      end
      if (frame_err === 1'b1) fe_seen++;
   endtask

   task automatic hold(input logic v, input int n);
      rx = v;
      repeat (n) tick();
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_good);
      hold(1'b0, BIT);
      for (int i = 0; i < 8; i++) hold(b[i], BIT);
      if (stop_good) hold(1'b1, 2 * BIT);
      else begin hold(1'b0, BIT); hold(1'b1, BIT); end
   endtask

   // 180 us BREAK, 20 us MAB
   task automatic send_break();
      hold(1'b1, BIT);
      hold(1'b0, 360);
      hold(1'b1, 40);
   endtask

   task automatic check_queues(input string nm);
      total++;
      if (exp_dv.size() != 0 || exp_pd.size() != 0) begin
         bad++;
         $display("FAIL %s_missing_pulses dv_left=%0d pd_left=%0d want=0", nm, exp_dv.size(), exp_pd.size());
         exp_dv.delete(); exp_pd.delete();
      end
   endtask

   task automatic check_zero_outputs(input string nm);
      total++;
      if ({dmx_data, data_valid, packet_done, last_slots, frame_err, signal_ok} !== '0) begin
         bad++;
         $display("FAIL %s_outputs data=%h dv=%b pd=%b slots=%0d fe=%b ok=%b want=all0",
                  nm, dmx_data, data_valid, packet_done, last_slots, frame_err, signal_ok);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; rx = 1'b1;
      repeat (4) tick();
      check_zero_outputs("reset");
      rst_n = 1'b1;
      repeat (20) tick();
      check_zero_outputs("post_reset");
   endtask

   task automatic test_basic();
      addr = 9'd1;
      send_break();
      send_byte(8'h00, 1'b1);
      exp_dv.push_back(8'hA5);
      send_byte(8'hA5, 1'b1);
      total++;
      if (dmx_data !== 8'hA5) begin bad++; $display("FAIL t1_data got=%h want=a5", dmx_data); end
      exp_pd.push_back(10'd1);
      send_break();
      check_queues("t1");
      total++;
      if (signal_ok !== 1'b1) begin bad++; $display("FAIL t1_signal_ok got=%b want=1", signal_ok); end
   endtask

   task automatic test_bad_start_code();
      addr = 9'd1;
      send_break();
      send_byte(8'hCC, 1'b1);
      send_byte(8'h55, 1'b1);
      send_break();
      check_queues("t2");
      total++;
      if (dmx_data !== 8'hA5) begin bad++; $display("FAIL t2_data_kept got=%h want=a5", dmx_data); end
   endtask

   task automatic test_frame_err();
      addr = 9'd1;
      send_break();
      send_byte(8'h00, 1'b1);
      fe_seen = 0;
      hold(1'b1, 10);
      hold(1'b0, 80);            // 40 us low pulse during MAB
      hold(1'b1, 20);
      send_byte(8'h12, 1'b0);    // low stop bit
      send_break();
      check_queues("t3");
      total++;
      if (fe_seen != 1) begin bad++; $display("FAIL t3_frame_err_count got=%0d want=1", fe_seen); end
   endtask

   task automatic test_full_packet();
      logic [7:0] b;
      addr = 9'd300;
      fe_seen = 0;
      send_break();
      send_byte(8'h00, 1'b1);
      for (int n = 1; n <= 512; n++) begin
         b = n[7:0];
         if (n == 300) exp_dv.push_back(8'h2C);
         if (n == 512) exp_pd.push_back(10'd512);
         send_byte(b, 1'b1);
      end
      check_queues("t4_after_512");
      send_break();
      check_queues("t4_next_break");
      total++;
      if (dmx_data !== 8'h2C) begin bad++; $display("FAIL t4_data got=%h want=2c", dmx_data); end
      total++;
      if (last_slots !== 10'd512) begin bad++; $display("FAIL t4_last_slots got=%0d want=512", last_slots); end
      total++;
      if (fe_seen != 0) begin bad++; $display("FAIL t4_frame_err got=%0d want=0", fe_seen); end
   endtask

   task automatic test_addr_timeout();
      addr = 9'd0;
      send_break();
      send_byte(8'h00, 1'b1);
      send_byte(8'h11, 1'b1);
      send_byte(8'h22, 1'b1);
      exp_pd.push_back(10'd2);
      send_break();
      check_queues("t5_addr0");
      total++;
      if (dmx_data !== 8'h2C) begin bad++; $display("FAIL t5_data_kept got=%h want=2c", dmx_data); end
      hold(1'b1, 1800);
      total++;
      if (signal_ok !== 1'b1) begin bad++; $display("FAIL t5_ok_before_timeout got=%b want=1", signal_ok); end
      hold(1'b1, 400);
      total++;
      if (signal_ok !== 1'b0) begin bad++; $display("FAIL t5_ok_after_timeout got=%b want=0", signal_ok); end
   endtask

   task automatic test_reset_mid_packet();
      logic [7:0] b;
      addr = 9'd1;
      b = 8'h5A;
      send_break();
      send_byte(8'h00, 1'b1);
      hold(1'b0, BIT);
      for (int i = 0; i < 3; i++) hold(b[i], BIT);
      rst_n = 1'b0;
      repeat (3) tick();
      check_zero_outputs("t6_reset");
      rx = 1'b1;
      rst_n = 1'b1;
      hold(1'b1, 30);
      check_zero_outputs("t6_released");
      send_break();
      send_byte(8'h00, 1'b1);
      exp_dv.push_back(8'h3C);
      send_byte(8'h3C, 1'b1);
      exp_pd.push_back(10'd1);
      send_break();
      check_queues("t6");
      total++;
      if (dmx_data !== 8'h3C) begin bad++; $display("FAIL t6_data got=%h want=3c", dmx_data); end
      total++;
      if (signal_ok !== 1'b1) begin bad++; $display("FAIL t6_signal_ok got=%b want=1", signal_ok); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_bad_start_code();
      test_frame_err();
      test_full_packet();
      test_addr_timeout();
      test_reset_mid_packet();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
